// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-entry command/response front end driving AXI4-Lite reads and writes,
// with a response-wait timeout, stale-response draining and a saturating latency counter.
module axi_lite_master_bridge #(
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [CNT_WIDTH-1:0]          rsp_cycles,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t state;
  logic [TW-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic stale_b, stale_r, b_hs, r_hs, expired, clear_ok;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign b_hs = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs = M_AXI_RVALID && M_AXI_RREADY;
  assign expired = TIMEOUT_CYCLES != 0 && int'(wait_cnt) + 1 == TIMEOUT_CYCLES;
  // A stale flag that is being drained on this very edge no longer blocks new commands.
  assign clear_ok = !(stale_b && !b_hs) && !(stale_r && !r_hs);
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      rsp_timeout <= 1'b0;
      rsp_cycles <= '0;
      M_AXI_AWADDR <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA <= '0;
      M_AXI_WSTRB <= '0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARADDR <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
      cnt <= '0;
      wait_cnt <= '0;
      stale_b <= 1'b0;
      stale_r <= 1'b0;
    end else begin
      if (stale_b && b_hs) begin
        stale_b <= 1'b0;
        M_AXI_BREADY <= 1'b0;
      end
      if (stale_r && r_hs) begin
        stale_r <= 1'b0;
        M_AXI_RREADY <= 1'b0;
      end
      case (state)
        IDLE:
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cnt <= '0;
            state <= cmd_write ? WR : RD;
            M_AXI_AWVALID <= cmd_write;
            M_AXI_WVALID <= cmd_write;
            M_AXI_ARVALID <= !cmd_write;
            M_AXI_AWADDR <= cmd_addr;
            M_AXI_ARADDR <= cmd_addr;
            M_AXI_WDATA <= cmd_wdata;
            M_AXI_WSTRB <= cmd_wstrb;
          end else cmd_ready <= clear_ok;
        WR: begin
          cnt <= cnt_inc;
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            state <= WR_RESP;
            M_AXI_BREADY <= 1'b1;
            wait_cnt <= '0;
          end
        end
        WR_RESP: begin
          cnt <= cnt_inc;
          wait_cnt <= wait_cnt + 1'b1;
          if (M_AXI_BVALID || expired) begin
            state <= RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp <= M_AXI_BVALID ? M_AXI_BRESP : 2'b10;
            rsp_timeout <= !M_AXI_BVALID;
            rsp_cycles <= cnt_inc;
            M_AXI_BREADY <= !M_AXI_BVALID;
            stale_b <= !M_AXI_BVALID;
          end
        end
        RD: begin
          cnt <= cnt_inc;
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            state <= RD_DATA;
            M_AXI_RREADY <= 1'b1;
            wait_cnt <= '0;
          end
        end
        RD_DATA: begin
          cnt <= cnt_inc;
          wait_cnt <= wait_cnt + 1'b1;
          if (M_AXI_RVALID || expired) begin
            state <= RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= M_AXI_RVALID ? M_AXI_RDATA : '0;
            rsp_resp <= M_AXI_RVALID ? M_AXI_RRESP : 2'b10;
            rsp_timeout <= !M_AXI_RVALID;
            rsp_cycles <= cnt_inc;
            M_AXI_RREADY <= !M_AXI_RVALID;
            stale_r <= !M_AXI_RVALID;
          end
        end
        RSP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= IDLE;
            cmd_ready <= clear_ok;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Synthesizable, parametrised AXI4-Lite master that turns a single-entry command/response interface into AXI4-Lite read and write transactions. It supersedes task-driven CPU bus modelling: the same block drives register-file DUTs in simulation and sits behind on-chip controllers in hardware. Beyond plain reads and writes, it adds per-command byte strobes, independent AW/W handshaking, a response-wait timeout with stale-response draining, and a latency counter.

## Interface
- M_AXI_DATA_WIDTH, default 32: data width; must be 32 or 64.
- M_AXI_ADDR_WIDTH, default 32: address width.
- TIMEOUT_CYCLES, default 1024: maximum wait for B/R; 0 disables the timeout.
- CNT_WIDTH, default 16: width of the latency counter (saturating).

Ports:
- M_AXI_ACLK  in  1  single clock, all logic on the rising edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  M_AXI_DATA_WIDTH/8  write strobes.
- rsp_valid / rsp_ready  out/in  1/1  response handshake.
- rsp_rdata  out  M_AXI_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction timed out.
- rsp_cycles  out  CNT_WIDTH  latency of the transaction.
- AXI4-Lite master ports (AW/W/B/AR/R), named as in the existing masters:
  - M_AXI_AWPROT and M_AXI_ARPROT tied to 3'b000.
  - M_AXI_WSTRB is registered from cmd_wstrb.

## Operation
- States are IDLE, WR, WR_RESP, RD, RD_DATA and RSP.
- **IDLE.** cmd_ready=1 only in IDLE with no stale response pending.
  - On accept, latch the command and clear the counter.
  - cmd_write=1 goes to WR; cmd_write=0 goes to RD.
- **WR.** AWVALID and WVALID both assert.
  - Each is deasserted independently in the cycle after its own handshake; either may complete first, or both together.
  - When both are done, go to WR_RESP.
- **WR_RESP.** BREADY=1.
  - On BVALID, capture BRESP and go to RSP.
- **RD.** ARVALID=1 until ARREADY, then go to RD_DATA.
- **RD_DATA.** RREADY=1.
  - On RVALID, capture RDATA and RRESP and go to RSP.
- **RSP.** rsp_valid=1 and rsp_* are held stable until rsp_ready, then go to IDLE.
- **Latency counter.**
  - Counts each clock edge from accept up to and including the final B or R handshake edge.
  - Saturates at 2^CNT_WIDTH-1.
- **Timeout.**
  - Counted only in WR_RESP and RD_DATA. VALIDs on AW/W/AR are never withdrawn before READY.
  - After TIMEOUT_CYCLES cycles without BVALID/RVALID, go to RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - Set stale_b or stale_r respectively.
- **Stale drain.**
  - While stale_b is set, BREADY=1 (stale_r: RREADY=1) in every state except WR_RESP/RD_DATA of a new transaction. In practice cmd_ready=0 until the stale flag clears, so no new transaction starts.
  - The flag clears on the late handshake, and that response is discarded.
- rsp_resp passes through RRESP/BRESP unmodified. SLVERR/DECERR are not retried.

## Timing
- **Reset values.**
  - All VALID/READY outputs = 0.
  - AWADDR, ARADDR, WDATA, WSTRB = 0.
  - rsp_* = 0 and stale flags = 0.
  - cmd_ready=1 one cycle after reset release (it is registered from state).
- **Reset asserted mid-transaction.** Outputs return to reset values immediately (asynchronously). The transaction is lost and no response is produced.
- **Zero-wait slave.**
  - Accept at edge 0.
  - AW/W handshake at edge 1.
  - B handshake at edge 2.
  - rsp_valid high after edge 2, with rsp_cycles=2.
  - Reads have the same timing.
- A command is accepted on the same edge as a rsp_ready handshake only if the state is IDLE. Back-to-back throughput is one transaction per (latency + 1 RSP cycle + 1 IDLE cycle).
- Timeout fires on the edge when the wait count equals TIMEOUT_CYCLES. If BVALID/RVALID arrives on that same edge, the real response wins and no timeout is reported.
- AXI outputs are all registered; there are no combinational paths from AXI inputs to AXI outputs.

## Test plan
- **Zero-wait write then read.** Write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then read 0x10 against a memory slave → rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_cycles=2 for both.
- **Skewed AW/W.** WREADY is 3 cycles before AWREADY, then the reverse → each VALID drops independently, exactly one B handshake occurs, and rsp_cycles reflects the later handshake.
- **Partial strobe.** Write 0x11223344 with wstrb 4'b0101 over 0xFFFFFFFF → read back 0xFF22FF44.
- **Error pass-through.** Slave returns BRESP=2'b11 → rsp_resp=2'b11, rsp_timeout=0.
- **Timeout and drain.** TIMEOUT_CYCLES=8 and the slave withholds RVALID → rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0 after 8 wait cycles. cmd_ready stays 0 until the late RVALID arrives 20 cycles later and is absorbed; the next read then returns correct data.
- **Reset mid-write.** Assert M_AXI_ARESETN low during WR_RESP → all outputs return to reset values that cycle, no rsp_valid occurs, and the next command after release completes normally.
